// File: rtl/tdc_pkg.sv
// Shared types and helpers for the carry-chain TDC reader.
package tdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILT = 2'd1,
    ST_ENC  = 2'd2,
    ST_HOLD = 2'd3
  } tdc_state_e;

  // Width needed to hold a ones count in the range 0..taps.
  function automatic int fw_of(input int taps);
    return $clog2(taps + 1);
  endfunction

endpackage

// File: rtl/tdc_ones_count.sv
// Combinational bubble filter (3-tap majority) followed by a popcount of the
// filtered thermometer code.
module tdc_ones_count
  import tdc_pkg::*;
#(
  parameter int TAPS = 16,
  parameter int FW   = fw_of(TAPS)
) (
  input  logic [TAPS-1:0] i_tap,
  output logic [FW-1:0]   o_count,
  output logic            o_full
);

  // Chain input side reads as one and the far end as zero.
  logic [TAPS+1:0] w_ext;
  logic [TAPS-1:0] w_filt;

  assign w_ext = {1'b0, i_tap, 1'b1};

  // Majority of each tap and its two neighbours removes single-tap bubbles.
  always_comb begin
    w_filt = {TAPS{1'b0}};
    for (int i = 0; i < TAPS; i++) begin
      w_filt[i] = (w_ext[i] & w_ext[i+1]) | (w_ext[i] & w_ext[i+2]) |
                  (w_ext[i+1] & w_ext[i+2]);
    end
  end

  // Ones count of the filtered code.
  always_comb begin
    o_count = {FW{1'b0}};
    for (int i = 0; i < TAPS; i++) begin
      o_count = o_count + FW'(w_filt[i]);
    end
  end

  assign o_full = &w_filt;

endmodule

// File: rtl/carry_tdc_reader.sv
// Carry-chain TDC reader: captures tap code and coarse count on HIT, filters,
// encodes and holds the result behind a VALID/READY handshake.
module carry_tdc_reader
  import tdc_pkg::*;
#(
  parameter int TAPS = 16,
  parameter int CW   = 8,
  parameter int FW   = fw_of(TAPS)
) (
  input  logic            C,
  input  logic            CLRN,
  input  logic [TAPS-1:0] TAP,
  input  logic            HIT,
  input  logic            READY,
  output logic            VALID,
  output logic [CW-1:0]   COARSE,
  output logic [FW-1:0]   FINE,
  output logic            OVF,
  output logic            DROP
);

  tdc_state_e      r_state;
  tdc_state_e      w_next;
  logic            w_accept;
  logic            r_armed;
  logic [CW-1:0]   r_cnt;
  logic [TAPS-1:0] r_tq;
  logic [CW-1:0]   r_cq;
  logic            r_valid;
  logic [CW-1:0]   r_coarse;
  logic [FW-1:0]   r_fine;
  logic            r_ovf;
  logic            r_drop;
  logic [FW-1:0]   w_fine;
  logic            w_ovf;

  tdc_ones_count #(.TAPS(TAPS), .FW(FW)) u_count (
    .i_tap   (r_tq),
    .o_count (w_fine),
    .o_full  (w_ovf)
  );

  // State register.
  always_ff @(posedge C or negedge CLRN) begin
    if (!CLRN) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next state and hit acceptance; r_armed marks the cycle after a capture,
  // which already counts as busy.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_armed) w_next = ST_FILT;
        else         w_next = ST_IDLE;
        if (HIT && !r_armed) w_accept = 1'b1;
        else                 w_accept = 1'b0;
      end
      ST_FILT: w_next = ST_ENC;
      ST_ENC:  w_next = ST_HOLD;
      ST_HOLD: begin
        if (READY) w_next = ST_IDLE;
        else       w_next = ST_HOLD;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Free-running coarse counter, capture registers and drop strobe.
  always_ff @(posedge C or negedge CLRN) begin
    if (!CLRN) begin
      r_cnt   <= {CW{1'b0}};
      r_tq    <= {TAPS{1'b0}};
      r_cq    <= {CW{1'b0}};
      r_armed <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_cnt   <= r_cnt + CW'(1);
      r_armed <= w_accept;
      r_drop  <= HIT & ~w_accept;
      if (w_accept) begin
        r_tq <= TAP;
        r_cq <= r_cnt;
      end
    end
  end

  // Result registers, loaded in ENC and held until the handshake.
  always_ff @(posedge C or negedge CLRN) begin
    if (!CLRN) begin
      r_valid  <= 1'b0;
      r_coarse <= {CW{1'b0}};
      r_fine   <= {FW{1'b0}};
      r_ovf    <= 1'b0;
    end else if (r_state == ST_ENC) begin
      r_valid  <= 1'b1;
      r_coarse <= r_cq;
      r_fine   <= w_fine;
      r_ovf    <= w_ovf;
    end else if (r_state == ST_HOLD && READY) begin
      r_valid  <= 1'b0;
    end
  end

  assign VALID  = r_valid;
  assign COARSE = r_coarse;
  assign FINE   = r_fine;
  assign OVF    = r_ovf;
  assign DROP   = r_drop;

endmodule

// File: tb/tb_carry_tdc_reader.sv
// Randomised scoreboard bench for carry_tdc_reader with a behavioural model.
module tb_carry_tdc_reader;

  localparam int TAPS = 16;
  localparam int CW   = 8;
  localparam int FW   = 5;

  typedef struct packed {
    logic [CW-1:0] coarse;
    logic [FW-1:0] fine;
    logic          ovf;
  } exp_t;

  logic            C = 1'b0;
  logic            CLRN = 1'b0;
  logic [TAPS-1:0] TAP = '0;
  logic            HIT = 1'b0;
  logic            READY = 1'b1;
  logic            VALID;
  logic [CW-1:0]   COARSE;
  logic [FW-1:0]   FINE;
  logic            OVF;
  logic            DROP;

  int errors = 0;
  int checks = 0;

  carry_tdc_reader #(.TAPS(TAPS), .CW(CW)) dut (
    .C(C), .CLRN(CLRN), .TAP(TAP), .HIT(HIT), .READY(READY),
    .VALID(VALID), .COARSE(COARSE), .FINE(FINE), .OVF(OVF), .DROP(DROP)
  );

  always #5 C = ~C;

  // Expected result from the filtering/counting rules.
  function automatic exp_t make_exp(input logic [TAPS-1:0] t, input int cnt);
    exp_t e;
    logic [TAPS-1:0] f;
    int a, b, c;
    for (int i = 0; i < TAPS; i++) begin
      a = (i == 0) ? 1 : int'(t[i-1]);
      b = int'(t[i]);
      c = (i == TAPS-1) ? 0 : int'(t[i+1]);
      f[i] = ((a + b + c) >= 2);
    end
    e.coarse = CW'(cnt % 256);
    e.fine   = FW'($countones(f));
    e.ovf    = ($countones(f) == TAPS);
    return e;
  endfunction

  // Behavioural model: edge count since reset, busy window, expected queue.
  exp_t sb_q[$];
  int   edge_n = 0;
  int   acc_edge = 0;
  bit   busy = 0;
  bit   exp_drop = 0;
  bit   exp_valid = 0;

  always @(posedge C or negedge CLRN) begin
    if (!CLRN) begin
      edge_n = 0; busy = 0; exp_drop = 0; exp_valid = 0;
      sb_q.delete();
    end else begin
      edge_n++;
      exp_drop = HIT && busy;
      if (busy && edge_n >= acc_edge + 4 && READY) begin
        busy = 0;
      end else if (!busy && HIT) begin
        busy = 1;
        acc_edge = edge_n;
        sb_q.push_back(make_exp(TAP, edge_n - 1));
      end
      exp_valid = busy && (edge_n >= acc_edge + 3);
    end
  end

  // Monitor: checks VALID/DROP every cycle, pops on each new result, checks hold.
  exp_t held;
  bit   prev_valid = 0;
  int   n_results = 0;
  int   n_drops = 0;

  always @(negedge C) begin
    exp_t e;
    checks++;
    if (VALID !== exp_valid) begin
      errors++; $display("FAIL valid t=%0t got=%b want=%b", $time, VALID, exp_valid);
    end
    checks++;
    if (DROP !== exp_drop) begin
      errors++; $display("FAIL drop t=%0t got=%b want=%b", $time, DROP, exp_drop);
    end
    if (DROP === 1'b1) n_drops++;
    if (VALID === 1'b1 && !prev_valid) begin
      n_results++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++; $display("FAIL unexpected_result t=%0t got coarse=%0d fine=%0d", $time, COARSE, FINE);
      end else begin
        e = sb_q.pop_front();
        held = e;
        if ({COARSE, FINE, OVF} !== e) begin
          errors++;
          $display("FAIL result t=%0t got c=%0d f=%0d o=%b want c=%0d f=%0d o=%b",
                   $time, COARSE, FINE, OVF, e.coarse, e.fine, e.ovf);
        end
      end
    end else if (VALID === 1'b1) begin
      checks++;
      if ({COARSE, FINE, OVF} !== held) begin
        errors++;
        $display("FAIL hold_stable t=%0t got c=%0d f=%0d o=%b want c=%0d f=%0d o=%b",
                 $time, COARSE, FINE, OVF, held.coarse, held.fine, held.ovf);
      end
    end
    prev_valid = (VALID === 1'b1);
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++; $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic send(input logic [TAPS-1:0] t);
    HIT = 1'b1; TAP = t;
    @(negedge C);
    HIT = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge C);
      if (!busy && sb_q.size() == 0 && !VALID) done = 1;
    end
    if (!done) begin
      checks++; errors++; $display("FAIL wait_idle timeout got=busy want=idle");
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_valid"},  int'(VALID),  0);
    check({name, "_drop"},   int'(DROP),   0);
    check({name, "_ovf"},    int'(OVF),    0);
    check({name, "_coarse"}, int'(COARSE), 0);
    check({name, "_fine"},   int'(FINE),   0);
  endtask

  initial begin
    int r0, d0;
    bit found;
    // Reset state
    repeat (3) @(negedge C);
    check_zero("reset");
    CLRN = 1'b1;
    // HIT sampled at edge 10 (CNT=9), result after edge 13
    repeat (9) @(negedge C);
    send(16'h00FF);
    repeat (2) @(negedge C);
    check("lat_before", int'(VALID), 0);
    @(negedge C);
    check("lat_valid", int'(VALID), 1);
    check("lat_coarse", int'(COARSE), 9);
    check("lat_fine", int'(FINE), 8);
    check("lat_ovf", int'(OVF), 0);
    wait_idle();

    // Directed codes
    send(16'h00F7); wait_idle();
    check("bubble_fine", int'(FINE), 8);
    send(16'h0000); wait_idle();
    check("empty_fine", int'(FINE), 0);
    send(16'hFFFF); wait_idle();
    check("full_fine", int'(FINE), 16);
    check("full_ovf", int'(OVF), 1);

    // Stall for 20 cycles with HIT every cycle
    READY = 1'b0;
    r0 = n_results;
    send(16'h0FFF);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge C);
      if (VALID) found = 1;
    end
    check("stall_valid_seen", int'(found), 1);
    d0 = n_drops;
    for (int i = 0; i < 20; i++) begin
      HIT = 1'b1; TAP = 16'($urandom);
      @(negedge C);
    end
    HIT = 1'b0;
    @(negedge C);
    check("stall_drops", n_drops - d0, 20);
    READY = 1'b1;
    wait_idle();
    check("stall_results", n_results - r0, 1);

    // Counter wrap: HIT at CNT=255, then at CNT=0
    found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge C);
      if (edge_n % 256 == 255) found = 1;
    end
    check("wrap255_found", int'(found), 1);
    send(16'h0003);
    repeat (3) @(negedge C);
    check("wrap_coarse255", int'(COARSE), 255);
    found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge C);
      if (edge_n % 256 == 0) found = 1;
    end
    check("wrap0_found", int'(found), 1);
    send(16'h003F);
    repeat (3) @(negedge C);
    check("wrap_coarse0", int'(COARSE), 0);
    wait_idle();

    // Reset while in ENC
    send(16'h07FF);
    repeat (2) @(negedge C);
    CLRN = 1'b0;
    #1;
    check_zero("midrst");
    repeat (2) @(negedge C);
    CLRN = 1'b1;
    repeat (6) @(negedge C);
    check("midrst_novalid", int'(VALID), 0);
    send(16'h001F);
    repeat (3) @(negedge C);
    check("midrst_next_valid", int'(VALID), 1);
    check("midrst_next_fine", int'(FINE), 5);
    wait_idle();

    // Back-to-back with READY held
    r0 = n_results; d0 = n_drops;
    for (int i = 0; i < 40; i++) begin
      HIT = 1'b1; TAP = 16'($urandom);
      @(negedge C);
    end
    HIT = 1'b0;
    wait_idle();
    check("b2b_results", n_results - r0, 8);
    check("b2b_drops", n_drops - d0, 32);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      HIT   = ($urandom_range(0, 3) == 0);
      READY = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 0) TAP = 16'($urandom);
      else TAP = 16'((32'h1 << $urandom_range(0, 16)) - 32'h1);
      @(negedge C);
    end
    HIT = 1'b0; READY = 1'b1;
    wait_idle();
    check("sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/carry_tdc_reader.md
CARRY_TDC_READER -- requirements
Module: carry_tdc_reader

Interface
REQ-001 Parameter TAPS, default 16, number of carry-chain taps sampled.
REQ-002 Parameter CW, default 8, coarse counter width.
REQ-003 Derived FW = clog2(TAPS+1), fine code width (5 at default).
REQ-004 C  input  1  clock; all state changes on rising edge.
REQ-005 CLRN  input  1  reset, asynchronous, active-low.
REQ-006 TAP  input  TAPS  thermometer code from carry-chain delay line; TAP[0] nearest chain input.
REQ-007 HIT  input  1  sample strobe; synchronous to C.
REQ-008 READY  input  1  downstream accepts result.
REQ-009 VALID  output  1  result available.
REQ-010 COARSE  output  CW  coarse count captured with the hit.
REQ-011 FINE  output  FW  bubble-corrected count of ones in the captured TAP.
REQ-012 OVF  output  1  captured code saturated: all taps one after correction.
REQ-013 DROP  output  1  one-cycle pulse: HIT ignored because block busy.

Function
REQ-014 Free-running counter CNT, CW bits, increments every cycle; wraps 2^CW-1 -> 0.
REQ-015 FSM states IDLE, FILT, ENC, HOLD; reset state IDLE.
REQ-016 IDLE: HIT=1 -> register TAP into T_Q and CNT into C_Q; go FILT. HIT=0 -> stay.
REQ-017 FILT: T_F[i] = majority(T_Q[i-1], T_Q[i], T_Q[i+1]), with T_Q[-1]=1 and T_Q[TAPS]=0; go ENC.
REQ-018 ENC: FINE <= popcount(T_F), range 0..TAPS; COARSE <= C_Q; OVF <= (T_F all ones); VALID <= 1; go HOLD.
REQ-019 Latency: HIT sampled at edge k -> VALID high after edge k+3.
REQ-020 HOLD: VALID, COARSE, FINE, OVF stable until VALID&READY seen at an edge.
REQ-021 VALID&READY at edge -> VALID low after that edge, state IDLE; next HIT accepted at the following edge at the earliest.
REQ-022 READY while VALID=0 has no effect.
REQ-023 HIT in FILT, ENC or HOLD (incl. same edge as READY handshake) -> not captured; DROP=1 for exactly the following cycle.
REQ-024 COARSE, FINE, OVF retain last values after handshake until next ENC.
REQ-025 Non-thermometer input: result defined solely by REQ-017/018; no error flag.

Reset
REQ-026 CLRN low -> immediately: state IDLE, VALID=0, DROP=0, OVF=0, COARSE=0, FINE=0, CNT=0, T_Q=0, C_Q=0.
REQ-027 Reset mid-operation (FILT/ENC/HOLD) discards the pending result; no VALID after release.
REQ-028 Reset release synchronous to C by the integrator; block counts from 0 on first edge after release.

Structure
REQ-029 Package tdc_pkg holds the FSM state enum and the FW width function.
REQ-030 Single sub-module tdc_ones_count: combinational bubble filter + popcount, parameter TAPS.
REQ-031 All registers in carry_tdc_reader; no latches; no combinational path TAP -> any output.

Verification
REQ-032 Reset, TAP=16'h00FF, HIT at edge 10 (CNT=9) -> VALID after edge 13, FINE=8, COARSE=9, OVF=0.
REQ-033 TAP=16'h00F7 (bubble at bit 3) -> FINE=8; TAP=16'h0000 -> FINE=0; TAP=16'hFFFF -> FINE=16, OVF=1.
REQ-034 READY=0 for 20 cycles after VALID -> outputs stable; HIT each of those cycles -> DROP pulses each, no second result.
REQ-035 CNT wrap: HIT at CNT=255 and at CNT=0 (CW=8) -> COARSE 255 then 0.
REQ-036 CLRN low during ENC -> VALID stays 0, all outputs zero; next HIT yields normal result 3 cycles later.
REQ-037 Back-to-back: READY held 1, HIT every cycle -> one result per 5 cycles, DROP on every busy-state HIT.
